// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
// Frame widths, command-bit encodings and FSM state enum.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_slave_fsm_if.sv
// spi_slave_fsm_if: serial pins plus the RAM-facing rx/tx bundle.
// slave is the FSM side; master is the host/RAM side.
interface spi_slave_fsm_if;
    import spi_pkg::*;

    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [CMD_W-1:0]  rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: 8-bit parallel-load MSB-first PISO for the MISO path.
// next_bit is the bit that becomes visible after the coming shift.
module spi_tx_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              next_bit,
    output logic              done
);

    logic [DATA_W-1:0] sr;
    logic [2:0]        cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[DATA_W-2:0], 1'b0};
            cnt <= cnt + 3'd1;
        end
    end

    assign next_bit = sr[DATA_W-2];
    // Bit 7 goes out on load, so seven shifts present the rest.
    assign done     = (cnt == 3'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: MOSI frame deserialiser and MISO serialiser.
// Tracks whether a read address is loaded to split READ_ADD/READ_DATA.
module spi_slave_fsm
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    spi_slave_fsm_if.slave bus
);

    spi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CMD_W-2:0] sr;
    logic [CMD_W-1:0] rx_data;
    logic             rx_valid;
    logic             miso;
    logic             rd_addr_done;

    logic sh_load;
    logic sh_shift;
    logic sh_next;
    logic sh_done;

    assign sh_load  = !bus.ss_n && (state == TX_WAIT) && bus.tx_valid;
    assign sh_shift = !bus.ss_n && (state == TX_SHIFT) && !sh_done;

    spi_tx_shifter u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .data     (bus.tx_data),
        .next_bit (sh_next),
        .done     (sh_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            miso         <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bus.ss_n) begin
                state <= IDLE;
                cnt   <= '0;
                miso  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        sr  <= {{(CMD_W-2){1'b0}}, bus.mosi};
                        cnt <= CNT_W'(1);
                        if (bus.mosi == CMD_WRITE)
                            state <= WRITE;
                        else if (rd_addr_done)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        sr  <= {sr[CMD_W-3:0], bus.mosi};
                        cnt <= cnt + CNT_W'(1);
                        // rx_data only moves on a complete frame.
                        if (cnt == CNT_W'(CMD_W - 1)) begin
                            rx_data  <= {sr, bus.mosi};
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            unique case (state)
                                READ_ADD: begin
                                    rd_addr_done <= 1'b1;
                                    state        <= DONE;
                                end
                                READ_DATA: begin
                                    rd_addr_done <= 1'b0;
                                    state        <= TX_WAIT;
                                end
                                default: state <= DONE;
                            endcase
                        end
                    end
                    TX_WAIT: begin
                        if (bus.tx_valid) begin
                            miso  <= bus.tx_data[DATA_W-1];
                            state <= TX_SHIFT;
                        end
                    end
                    TX_SHIFT: begin
                        if (sh_done) begin
                            miso  <= 1'b0;
                            state <= DONE;
                        end else begin
                            miso <= sh_next;
                        end
                    end
                    DONE: miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.miso     = miso;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: directed frames against hand-computed expectations.
// Includes a 1-cycle-latency RAM read model returning 0xA5.
module tb_spi_slave_fsm;
    import spi_pkg::*;

    logic clk;
    logic rst;
    int   n_asrt;
    int   n_fail;
    logic [7:0] exp_b;

    spi_slave_fsm_if bus ();

    spi_slave_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        bus.tx_valid <= bus.rx_valid && (bus.rx_data[9:8] == 2'b11);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [9:0] f, input int n);
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk);
            bus.ss_n = 1'b0;
            bus.mosi = f[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.ss_n = 1'b1;
        @(posedge clk);
        #1;
        check("rxv_clr", 32'(bus.rx_valid), 0);
        check("st_idle", 32'(dut.state), 32'(IDLE));
    endtask

    task automatic full_frame(input string tag, input logic [9:0] f);
        send_bits(f, 9);
        check({tag, "_rxv_pre"}, 32'(bus.rx_valid), 0);
        send_bits(10'(f << 9), 1);
        check({tag, "_rxv"}, 32'(bus.rx_valid), 1);
        check({tag, "_data"}, 32'(bus.rx_data), 32'(f));
    endtask

    initial begin
        n_asrt       = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_miso", 32'(bus.miso), 0);
        check("rst_rxd", 32'(bus.rx_data), 0);
        check("rst_rxv", 32'(bus.rx_valid), 0);
        check("rst_st", 32'(dut.state), 32'(IDLE));
        check("rst_rd", 32'(dut.rd_addr_done), 0);
        @(negedge clk);
        rst = 1'b0;

        full_frame("wa", 10'h03C);
        end_frame();
        full_frame("wd", 10'h1A5);
        end_frame();

        full_frame("ra", 10'h23C);
        check("ra_rd", 32'(dut.rd_addr_done), 1);
        check("ra_st", 32'(dut.state), 32'(DONE));
        end_frame();

        full_frame("rd", 10'h300);
        check("rd_rd", 32'(dut.rd_addr_done), 0);
        check("rd_st", 32'(dut.state), 32'(TX_WAIT));
        @(posedge clk);
        #1;
        check("rd_e11_miso", 32'(bus.miso), 0);
        exp_b = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk);
            #1;
            check($sformatf("rd_miso%0d", i), 32'(bus.miso), 32'(exp_b[i]));
        end
        @(posedge clk);
        #1;
        check("rd_e20_st", 32'(dut.state), 32'(DONE));
        check("rd_e20_miso", 32'(bus.miso), 0);
        end_frame();

        full_frame("rr", 10'h300);
        check("rr_rd", 32'(dut.rd_addr_done), 1);
        check("rr_st", 32'(dut.state), 32'(DONE));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rr_st_hold", 32'(dut.state), 32'(DONE));
            check("rr_miso", 32'(bus.miso), 0);
        end
        end_frame();

        send_bits(10'h0FF, 6);
        @(negedge clk);
        bus.ss_n = 1'b1;
        @(posedge clk);
        #1;
        check("ab_rxv", 32'(bus.rx_valid), 0);
        check("ab_st", 32'(dut.state), 32'(IDLE));
        check("ab_rxd", 32'(bus.rx_data), 32'h300);
        check("ab_rd", 32'(dut.rd_addr_done), 1);
        @(posedge clk);
        #1;
        check("ab_rxv2", 32'(bus.rx_valid), 0);

        send_bits(10'h155, 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_rxd", 32'(bus.rx_data), 0);
        check("mr_rxv", 32'(bus.rx_valid), 0);
        check("mr_miso", 32'(bus.miso), 0);
        check("mr_st", 32'(dut.state), 32'(IDLE));
        check("mr_rd", 32'(dut.rd_addr_done), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.ss_n = 1'b1;
        @(posedge clk);
        #1;
        full_frame("pr", 10'h0AB);
        check("pr_st", 32'(dut.state), 32'(DONE));
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
